fifo_burst_reader: RTL and testbench

//  Read-domain consumer for async_fifo (normal mode, 1-cycle read latency). Waits

---
 rtl/fifo_burst_reader.sv | 179 +++++++++++++++++
 tb/tb_fifo_burst_reader.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_burst_reader
// Purpose  : Read-side consumer for an async FIFO. Drains BURST_LEN-word
//            bursts as a framed valid/ready stream. Partial tails are flushed
//            after an idle timeout.
// Revision : 1.0  initial release
// ============================================================================
module fifo_burst_reader #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 9,
    parameter int BURST_LEN = 16,
    parameter int TIMEOUT   = 256,
    parameter int LEN_W     = $clog2(BURST_LEN + 1)
) (
    input  logic              rdclk,
    input  logic              rst_n,
    output logic              fifo_rdreq,
    input  logic [DATA_W-1:0] fifo_rddout,
    input  logic              fifo_rdempty,
    input  logic [ADDR_W-1:0] fifo_rdusedw,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_sop,
    output logic              m_eop,
    output logic [LEN_W-1:0]  m_len,
    output logic              busy
);

    localparam int                 AVAIL_W      = ADDR_W + 1;
    localparam logic [AVAIL_W-1:0] c_FIFO_DEPTH = AVAIL_W'(2 ** ADDR_W);
    localparam logic [AVAIL_W-1:0] c_BURST_AV   = AVAIL_W'(BURST_LEN);
    localparam logic [LEN_W-1:0]   c_BURST_LEN  = LEN_W'(BURST_LEN);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t              r_state;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_rd_left;
    logic [LEN_W-1:0]    r_wcnt;
    logic                r_busy;
    logic                r_inflight;
    logic [1:0]          r_cnt;
    logic [DATA_W-1:0]   r_buf0;
    logic [DATA_W-1:0]   r_buf1;

    logic [AVAIL_W-1:0]  w_avail;
    logic                w_full_start;
    logic                w_tmo_start;
    logic                w_start;
    logic [LEN_W-1:0]    w_start_len;
    logic                w_hs;
    logic                w_last_hs;
    logic                w_push;
    logic [1:0]          w_occ;
    logic                w_rdreq;

    // A completely full FIFO reports usedw==0 while not empty.
    assign w_avail      = (fifo_rdusedw == '0 && !fifo_rdempty) ? c_FIFO_DEPTH
                                                               : {1'b0, fifo_rdusedw};
    assign w_full_start = (w_avail >= c_BURST_AV);
    assign w_start      = (r_state == S_IDLE) && (w_full_start || w_tmo_start);
    assign w_start_len  = w_full_start ? c_BURST_LEN : LEN_W'(w_avail);

    generate
        if (TIMEOUT != 0) begin : g_tmo
            localparam int               TMO_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            localparam logic [TMO_W-1:0] c_TMO_LAST = TMO_W'(TIMEOUT - 1);
            logic [TMO_W-1:0] r_tmo_cnt;

            assign w_tmo_start = !fifo_rdempty && (r_tmo_cnt == c_TMO_LAST);

            always_ff @(posedge rdclk or negedge rst_n) begin
                if (!rst_n) begin
                    r_tmo_cnt <= '0;
                end else if (r_state != S_IDLE || fifo_rdempty || w_start) begin
                    r_tmo_cnt <= '0;
                end else begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                end
            end
        end else begin : g_no_tmo
            assign w_tmo_start = 1'b0;
        end
    endgenerate

    assign w_hs      = m_valid && m_ready;
    assign w_last_hs = w_hs && m_eop;
    assign w_push    = r_inflight;

    // Occupancy after this cycle's pop; counting the pop keeps 1 word/cycle.
    assign w_occ   = r_cnt + {1'b0, r_inflight} - {1'b0, w_hs};
    assign w_rdreq = (r_state == S_BURST) && (r_rd_left != '0) &&
                     !fifo_rdempty && (w_occ < 2'd2);

    assign fifo_rdreq = w_rdreq;
    assign m_valid    = (r_cnt != 2'd0);
    assign m_data     = r_buf0;
    assign m_sop      = m_valid && (r_wcnt == '0);
    assign m_eop      = m_valid && (r_wcnt == r_len - 1'b1);
    assign m_len      = r_len;
    assign busy       = r_busy;

    always_ff @(posedge rdclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_len     <= '0;
            r_rd_left <= '0;
            r_wcnt    <= '0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state   <= S_BURST;
                        r_len     <= w_start_len;
                        r_rd_left <= w_start_len;
                        r_wcnt    <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                S_BURST: begin
                    if (w_rdreq) begin
                        r_rd_left <= r_rd_left - 1'b1;
                    end
                    if (w_last_hs) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_wcnt  <= '0;
                    end else if (w_hs) begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Two-entry skid buffer; r_buf0 is always the head.
    always_ff @(posedge rdclk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
            r_cnt      <= 2'd0;
            r_buf0     <= '0;
            r_buf1     <= '0;
        end else begin
            r_inflight <= w_rdreq;
            case ({w_push, w_hs})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_buf0 <= fifo_rddout;
                    end else begin
                        r_buf1 <= fifo_rddout;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_buf0 <= r_buf1;
                    r_cnt  <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_buf0 <= fifo_rddout;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= fifo_rddout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_burst_reader
// Purpose  : Self-checking bench for fifo_burst_reader (three configurations).
// Revision : 1.0  initial release
// ============================================================================
module tb_fifo_burst_reader;

    localparam int NI = 3;
    localparam int BL = 16;

    typedef struct {
        int         inst;
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic [4:0] len;
    } rec_t;

    typedef struct {
        int inst;
        int nwords;
        int ready_pct;
        int exp_full;
        int exp_tail;
    } case_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       rdreq [NI];
    logic       empty [NI];
    logic       valid [NI];
    logic       ready [NI];
    logic       sop   [NI];
    logic       eop   [NI];
    logic       busy  [NI];
    logic [7:0] dout  [NI];
    logic [7:0] data  [NI];
    logic [4:0] len   [NI];
    logic [8:0] usedw_a;
    logic [3:0] usedw_b;
    logic [8:0] usedw_c;

    logic [7:0] fq [NI][$];
    int         fcnt [NI];
    int         tmo_of [NI] = '{256, 4, 0};

    rec_t       act[$];
    logic [7:0] exp_words[$];
    int         exp_lens[$];
    int         nrd [NI];
    int         nhs [NI];
    logic       stall [NI];
    logic [7:0] held [NI];
    int         vec = 0;
    int         bad = 0;

    assign usedw_a  = 9'(fcnt[0]);
    assign usedw_b  = 4'(fcnt[1]);
    assign usedw_c  = 9'(fcnt[2]);
    assign empty[0] = (fcnt[0] == 0);
    assign empty[1] = (fcnt[1] == 0);
    assign empty[2] = (fcnt[2] == 0);

    fifo_burst_reader #(.DATA_W(8), .ADDR_W(9), .BURST_LEN(16), .TIMEOUT(256)) u_dut_a (
        .rdclk(clk), .rst_n(rst_n), .fifo_rdreq(rdreq[0]), .fifo_rddout(dout[0]),
        .fifo_rdempty(empty[0]), .fifo_rdusedw(usedw_a), .m_valid(valid[0]),
        .m_ready(ready[0]), .m_data(data[0]), .m_sop(sop[0]), .m_eop(eop[0]),
        .m_len(len[0]), .busy(busy[0])
    );

    fifo_burst_reader #(.DATA_W(8), .ADDR_W(4), .BURST_LEN(16), .TIMEOUT(4)) u_dut_b (
        .rdclk(clk), .rst_n(rst_n), .fifo_rdreq(rdreq[1]), .fifo_rddout(dout[1]),
        .fifo_rdempty(empty[1]), .fifo_rdusedw(usedw_b), .m_valid(valid[1]),
        .m_ready(ready[1]), .m_data(data[1]), .m_sop(sop[1]), .m_eop(eop[1]),
        .m_len(len[1]), .busy(busy[1])
    );

    fifo_burst_reader #(.DATA_W(8), .ADDR_W(9), .BURST_LEN(16), .TIMEOUT(0)) u_dut_c (
        .rdclk(clk), .rst_n(rst_n), .fifo_rdreq(rdreq[2]), .fifo_rddout(dout[2]),
        .fifo_rdempty(empty[2]), .fifo_rdusedw(usedw_c), .m_valid(valid[2]),
        .m_ready(ready[2]), .m_data(data[2]), .m_sop(sop[2]), .m_eop(eop[2]),
        .m_len(len[2]), .busy(busy[2])
    );

    // Behavioural FIFO: 1-cycle read latency, counts visible after the edge.
    always @(posedge clk) begin : fifo_model
        logic [7:0] t;
        for (int i = 0; i < NI; i++) begin
            if (rdreq[i] && fq[i].size() > 0) begin
                t = fq[i].pop_front();
                dout[i] <= t;
            end
            fcnt[i] <= fq[i].size();
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                nrd[i]   = 0;
                nhs[i]   = 0;
                stall[i] = 1'b0;
            end else begin
                if (stall[i] === 1'b1) begin
                    vec++;
                    if (valid[i] !== 1'b1 || data[i] !== held[i]) begin
                        bad++;
                        $display("FAIL hold inst%0d: valid=%0b data=%02h, required valid=1 data=%02h",
                                 i, valid[i], data[i], held[i]);
                    end
                end
                if (valid[i] && ready[i]) begin
                    act.push_back('{i, data[i], sop[i], eop[i], len[i]});
                    nhs[i]++;
                end
                if (rdreq[i]) begin
                    nrd[i]++;
                    vec++;
                    if (nrd[i] - nhs[i] > 2 || busy[i] !== 1'b1) begin
                        bad++;
                        $display("FAIL rdreq inst%0d: outstanding=%0d busy=%0b, required <=2 and busy=1",
                                 i, nrd[i] - nhs[i], busy[i]);
                    end
                end
                stall[i] = valid[i] && !ready[i];
                held[i]  = data[i];
            end
        end
    end

    task automatic check(string name, logic [31:0] a, logic [31:0] r);
        vec++;
        if (a !== r) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, a, r);
        end
    endtask

    task automatic check_zero(int i, string tag);
        check($sformatf("%s inst%0d m_valid", tag, i), 32'(valid[i]), 0);
        check($sformatf("%s inst%0d m_sop", tag, i), 32'(sop[i]), 0);
        check($sformatf("%s inst%0d m_eop", tag, i), 32'(eop[i]), 0);
        check($sformatf("%s inst%0d m_len", tag, i), 32'(len[i]), 0);
        check($sformatf("%s inst%0d busy", tag, i), 32'(busy[i]), 0);
        check($sformatf("%s inst%0d rdreq", tag, i), 32'(rdreq[i]), 0);
        check($sformatf("%s inst%0d m_data", tag, i), 32'(data[i]), 0);
    endtask

    task automatic preload(int inst, int n, bit incr);
        exp_words.delete();
        for (int k = 0; k < n; k++) begin
            logic [7:0] w;
            w = incr ? 8'(k) : 8'($urandom);
            fq[inst].push_back(w);
            exp_words.push_back(w);
        end
    endtask

    // Full bursts while enough words remain; a tail only if flushing is enabled.
    task automatic model_lens(int n, int tmo);
        exp_lens.delete();
        while (n >= BL) begin
            exp_lens.push_back(BL);
            n -= BL;
        end
        if (n > 0 && tmo != 0) exp_lens.push_back(n);
    endtask

    task automatic compare_stream(string name, int inst);
        rec_t e[$];
        int   p = 0;
        foreach (exp_lens[b]) begin
            for (int k = 0; k < exp_lens[b]; k++) begin
                e.push_back('{inst, exp_words[p], k == 0, k == exp_lens[b] - 1, 5'(exp_lens[b])});
                p++;
            end
        end
        check({name, " word count"}, act.size(), e.size());
        for (int j = 0; j < act.size() && j < e.size(); j++) begin
            vec++;
            if (act[j].inst != e[j].inst || act[j].data !== e[j].data || act[j].sop !== e[j].sop ||
                act[j].eop !== e[j].eop || act[j].len !== e[j].len) begin
                bad++;
                $display("FAIL %s word%0d: got inst%0d data=%02h sop=%0b eop=%0b len=%0d, required inst%0d data=%02h sop=%0b eop=%0b len=%0d",
                         name, j, act[j].inst, act[j].data, act[j].sop, act[j].eop, act[j].len,
                         e[j].inst, e[j].data, e[j].sop, e[j].eop, e[j].len);
            end
        end
    endtask

    task automatic run_stream(string name, int inst, int pct, int bound, int settle);
        int cyc  = 0;
        int need = 0;
        foreach (exp_lens[b]) need += exp_lens[b];
        while (act.size() < need && cyc < bound) begin
            @(posedge clk); #1;
            ready[inst] = (int'($urandom_range(99)) < pct);
            cyc++;
        end
        check({name, " completed in budget"}, 32'(act.size() >= need), 1);
        ready[inst] = 1'b1;
        repeat (settle) @(posedge clk);
        #1;
        check({name, " busy low"}, 32'(busy[inst]), 0);
        compare_stream(name, inst);
    endtask

    case_t tbl[6];

    initial begin
        tbl[0] = '{0, 40, 100, 2, 8};
        tbl[1] = '{0, 16,  50, 1, 0};
        tbl[2] = '{1, 16, 100, 1, 0};
        tbl[3] = '{1,  1, 100, 0, 1};
        tbl[4] = '{2, 40, 100, 2, 0};
        tbl[5] = '{1,  7,  60, 0, 7};

        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) ready[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) check_zero(i, "reset");
        rst_n = 1'b1;

        // Single full burst, incrementing data, checked cycle by cycle.
        @(posedge clk); #1;
        act.delete();
        preload(0, 16, 1'b1);
        ready[0] = 1'b1;
        begin
            int w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!busy[0] && w < 50);
            check("t1 busy rises", 32'(busy[0]), 1);
            check("t1 valid at start", 32'(valid[0]), 0);
            @(negedge clk);
            check("t1 valid start+1", 32'(valid[0]), 0);
            @(negedge clk);
            check("t1 valid start+2", 32'(valid[0]), 1);
            check("t1 first sop", 32'(sop[0]), 1);
            check("t1 m_len", 32'(len[0]), 16);
            w = 0;
            repeat (15) begin
                @(negedge clk);
                if (!valid[0]) w++;
            end
            check("t1 bubbles", w, 0);
            @(negedge clk);
            check("t1 busy after eop", 32'(busy[0]), 0);
            check("t1 rdreq count", nrd[0], 16);
        end
        model_lens(16, tmo_of[0]);
        compare_stream("t1", 0);

        foreach (tbl[r]) begin
            @(posedge clk); #1;
            act.delete();
            preload(tbl[r].inst, tbl[r].nwords, 1'b0);
            exp_lens.delete();
            repeat (tbl[r].exp_full) exp_lens.push_back(BL);
            if (tbl[r].exp_tail != 0) exp_lens.push_back(tbl[r].exp_tail);
            run_stream($sformatf("row%0d", r), tbl[r].inst, tbl[r].ready_pct, 2000,
                       (tbl[r].inst == 2) ? 600 : 20);
            if (tbl[r].inst == 2) check("no-flush leftover", fcnt[2], 8);
        end

        for (int r = 0; r < 6; r++) begin
            int inst;
            int n;
            inst = int'($urandom_range(1));
            n    = (inst == 0) ? int'($urandom_range(40, 1)) : int'($urandom_range(16, 1));
            @(posedge clk); #1;
            act.delete();
            preload(inst, n, 1'b0);
            model_lens(n, tmo_of[inst]);
            run_stream($sformatf("rand%0d n=%0d", r, n), inst, int'($urandom_range(100, 30)), 3000, 20);
        end

        // Reset while word 5 of a burst is presented.
        @(posedge clk); #1;
        act.delete();
        preload(0, 40, 1'b0);
        ready[0] = 1'b1;
        begin
            int w = 0;
            while (act.size() < 5 && w < 200) begin
                @(posedge clk); #1;
                w++;
            end
        end
        check("abort at word5", act.size(), 5);
        check("abort word5 valid", 32'(valid[0]), 1);
        rst_n = 1'b0;
        #1;
        check_zero(0, "abort");
        repeat (2) @(posedge clk);
        #1;
        act.delete();
        exp_words = fq[0];
        model_lens(fq[0].size(), tmo_of[0]);
        rst_n = 1'b1;
        run_stream("post-abort", 0, 100, 3000, 20);

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
